// File: rtl/win_detector.sv
// Sequential tic-tac-toe judge: snapshots both boards on check, scans the 8 lines
// one per clock, then reports win / draw / no result and holds it until newGame.
module win_detector (
    input  logic       CLK_100MHZ,
    input  logic       reset,
    input  logic       check,
    input  logic       newGame,
    input  logic [8:0] boardX,
    input  logic [8:0] boardO,
    output logic       incrementX,
    output logic       incrementO,
    output logic [1:0] winner,
    output logic [2:0] winLine,
    output logic       draw,
    output logic       gameOver,
    output logic       busy
);

    // state | meaning
    // IDLE  | waiting for check; result outputs are 0
    // SCAN  | testing line[cnt] against both shadow boards, one line per clock
    // EVAL  | single cycle: load result registers and pulse the winner's increment
    // DONE  | result held; check ignored until newGame
    typedef enum logic [1:0] {IDLE, SCAN, EVAL, DONE} state_t;

    state_t     state, state_next;
    logic [8:0] shadow_x, shadow_o;
    logic [2:0] cnt;
    logic       hit_x, hit_o;
    logic [2:0] line_x, line_o;
    logic [8:0] line_mask;
    logic       line_x_now, line_o_now, board_full;

    always_comb begin
        line_mask = 9'h000;
        case (cnt)
            3'd0: line_mask = 9'b000_000_111;
            3'd1: line_mask = 9'b000_111_000;
            3'd2: line_mask = 9'b111_000_000;
            3'd3: line_mask = 9'b001_001_001;
            3'd4: line_mask = 9'b010_010_010;
            3'd5: line_mask = 9'b100_100_100;
            3'd6: line_mask = 9'b100_010_001;
            3'd7: line_mask = 9'b001_010_100;
            default: line_mask = 9'h000;
        endcase
    end

    assign line_x_now = (shadow_x & line_mask) == line_mask;
    assign line_o_now = (shadow_o & line_mask) == line_mask;
    assign board_full = (shadow_x | shadow_o) == 9'h1FF;

    always_ff @(posedge CLK_100MHZ) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (check) state_next = SCAN;
            SCAN:    if (cnt == 3'd7) state_next = EVAL;
            EVAL:    state_next = (hit_x || hit_o || board_full) ? DONE : IDLE;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
        // newGame overrides everything, including a same-cycle check
        if (newGame) state_next = IDLE;
    end

    always_ff @(posedge CLK_100MHZ) begin
        if (!reset) begin
            shadow_x   <= 9'h000;
            shadow_o   <= 9'h000;
            cnt        <= 3'd0;
            hit_x      <= 1'b0;
            hit_o      <= 1'b0;
            line_x     <= 3'd0;
            line_o     <= 3'd0;
            winner     <= 2'b00;
            winLine    <= 3'd0;
            draw       <= 1'b0;
            incrementX <= 1'b0;
            incrementO <= 1'b0;
        end else begin
            incrementX <= 1'b0;
            incrementO <= 1'b0;
            if (newGame) begin
                hit_x   <= 1'b0;
                hit_o   <= 1'b0;
                winner  <= 2'b00;
                winLine <= 3'd0;
                draw    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (check) begin
                            shadow_x <= boardX;
                            shadow_o <= boardO;
                            hit_x    <= 1'b0;
                            hit_o    <= 1'b0;
                            cnt      <= 3'd0;
                        end
                    end
                    SCAN: begin
                        cnt <= cnt + 3'd1;
                        // keep only the first line found for each player
                        if (line_x_now && !hit_x) begin
                            hit_x  <= 1'b1;
                            line_x <= cnt;
                        end
                        if (line_o_now && !hit_o) begin
                            hit_o  <= 1'b1;
                            line_o <= cnt;
                        end
                    end
                    EVAL: begin
                        if (hit_x) begin
                            winner     <= 2'b01;
                            winLine    <= line_x;
                            incrementX <= 1'b1;
                        end else if (hit_o) begin
                            winner     <= 2'b10;
                            winLine    <= line_o;
                            incrementO <= 1'b1;
                        end else if (board_full) begin
                            draw <= 1'b1;
                        end else begin
                            winner  <= 2'b00;
                            winLine <= 3'd0;
                            draw    <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign gameOver = (winner != 2'b00) || draw;
    assign busy     = (state == SCAN) || (state == EVAL);

endmodule

// File: tb/tb_win_detector.sv
// Directed bench for win_detector: hand-computed results for wins, draw, no result,
// aborts, priority and ignored requests, sampled on the falling clock edge.
module tb_win_detector;

    logic       CLK_100MHZ = 1'b0;
    logic       reset = 1'b0;
    logic       check = 1'b0;
    logic       newGame = 1'b0;
    logic [8:0] boardX = 9'h000;
    logic [8:0] boardO = 9'h000;
    logic       incrementX, incrementO, draw, gameOver, busy;
    logic [1:0] winner;
    logic [2:0] winLine;

    int checks = 0;
    int errors = 0;

    win_detector dut (
        .CLK_100MHZ(CLK_100MHZ),
        .reset     (reset),
        .check     (check),
        .newGame   (newGame),
        .boardX    (boardX),
        .boardO    (boardO),
        .incrementX(incrementX),
        .incrementO(incrementO),
        .winner    (winner),
        .winLine   (winLine),
        .draw      (draw),
        .gameOver  (gameOver),
        .busy      (busy)
    );

    always #5 CLK_100MHZ = ~CLK_100MHZ;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK_100MHZ);
    endtask

    // {incX, incO, winner, winLine, draw, gameOver, busy}
    task automatic chk_all(input string tag, input logic ix, input logic io, input logic [1:0] w,
                           input logic [2:0] l, input logic d, input logic g, input logic b);
        chk({tag, ".incX"}, 16'(incrementX), 16'(ix));
        chk({tag, ".incO"}, 16'(incrementO), 16'(io));
        chk({tag, ".winner"}, 16'(winner), 16'(w));
        chk({tag, ".winLine"}, 16'(winLine), 16'(l));
        chk({tag, ".draw"}, 16'(draw), 16'(d));
        chk({tag, ".gameOver"}, 16'(gameOver), 16'(g));
        chk({tag, ".busy"}, 16'(busy), 16'(b));
    endtask

    // leaves the bench just after edge 0
    task automatic do_check(input logic [8:0] bx, input logic [8:0] bo);
        boardX = bx;
        boardO = bo;
        check  = 1'b1;
        tick();
        check  = 1'b0;
    endtask

    // edges 1..8 busy with no pulse, then advance past edge 9
    task automatic run_scan(input string tag);
        chk({tag, ".busy_e0"}, 16'(busy), 16'd1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk({tag, ".busy_scan"}, 16'(busy), 16'd1);
            chk({tag, ".nopulse_scan"}, 16'({incrementX, incrementO}), 16'd0);
        end
        tick();
    endtask

    task automatic new_game(input string tag);
        newGame = 1'b1;
        tick();
        newGame = 1'b0;
        chk_all({tag, ".newgame"}, 0, 0, 2'b00, 3'd0, 0, 0, 0);
    endtask

    initial begin
        tick();
        tick();
        chk_all("reset", 0, 0, 2'b00, 3'd0, 0, 0, 0);
        reset = 1'b1;
        tick();
        chk_all("idle", 0, 0, 2'b00, 3'd0, 0, 0, 0);

        // top-row X win
        do_check(9'h007, 9'h018);
        run_scan("xrow");
        chk_all("xrow.e9", 1, 0, 2'b01, 3'd0, 0, 1, 0);
        tick();
        chk_all("xrow.e10", 0, 0, 2'b01, 3'd0, 0, 1, 0);
        new_game("xrow");

        // anti-diagonal O win, then a check in DONE is ignored
        do_check(9'h003, 9'h054);
        run_scan("oanti");
        chk_all("oanti.e9", 0, 1, 2'b10, 3'd7, 0, 1, 0);
        do_check(9'h003, 9'h054);
        for (int i = 0; i < 12; i++) begin
            chk_all("oanti.done_ignore", 0, 0, 2'b10, 3'd7, 0, 1, 0);
            tick();
        end
        new_game("oanti");

        // genuine full-board draw: X O X / X O O / O X X
        do_check(9'h18D, 9'h072);
        run_scan("draw");
        chk_all("draw.e9", 0, 0, 2'b00, 3'd0, 1, 1, 0);
        do_check(9'h001, 9'h000);
        chk_all("draw.ignore", 0, 0, 2'b00, 3'd0, 1, 1, 0);
        new_game("draw");

        // no result, then an immediate re-check at edge 10
        do_check(9'h001, 9'h010);
        run_scan("none");
        chk_all("none.e9", 0, 0, 2'b00, 3'd0, 0, 0, 0);
        do_check(9'h001, 9'h010);
        run_scan("none2");
        chk_all("none2.e9", 0, 0, 2'b00, 3'd0, 0, 0, 0);

        // newGame at edge 4 aborts the scan
        do_check(9'h007, 9'h000);
        tick(); tick(); tick();
        newGame = 1'b1;
        tick();
        newGame = 1'b0;
        chk_all("abort_ng.e4", 0, 0, 2'b00, 3'd0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_all("abort_ng.after", 0, 0, 2'b00, 3'd0, 0, 0, 0);
        end

        // reset at edge 4 aborts the scan
        do_check(9'h007, 9'h000);
        tick(); tick(); tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk_all("abort_rst.e4", 0, 0, 2'b00, 3'd0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_all("abort_rst.after", 0, 0, 2'b00, 3'd0, 0, 0, 0);
        end

        // board changes during SCAN do not matter
        do_check(9'h007, 9'h018);
        boardX = 9'h000;
        boardO = 9'h1C0;
        run_scan("snap");
        chk_all("snap.e9", 1, 0, 2'b01, 3'd0, 0, 1, 0);
        new_game("snap");

        // both players own a line: X wins
        do_check(9'h007, 9'h1C0);
        run_scan("prio");
        chk_all("prio.e9", 1, 0, 2'b01, 3'd0, 0, 1, 0);
        tick();
        chk_all("prio.e10", 0, 0, 2'b01, 3'd0, 0, 1, 0);
        new_game("prio");

        // O owns rows 0 and 2: the first line found is reported
        do_check(9'h000, 9'h1C7);
        run_scan("first");
        chk_all("first.e9", 0, 1, 2'b10, 3'd0, 0, 1, 0);
        new_game("first");

        // simultaneous check and newGame in IDLE: nothing starts
        boardX  = 9'h007;
        check   = 1'b1;
        newGame = 1'b1;
        tick();
        check   = 1'b0;
        newGame = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk_all("cknew", 0, 0, 2'b00, 3'd0, 0, 0, 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
